// File: rtl/asg_loader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// asg_loader_pkg : shared types and constants for the ASG stream loader.
// Rev 1.0
// ---------------------------------------------------------------------------
package asg_loader_pkg;

  localparam int c_guard_default = 16;
  localparam int c_sample_w      = 14;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/asg_loader_fill.sv
`default_nettype none
// ---------------------------------------------------------------------------
// asg_loader_fill : buffer fill level, previous-cycle fill, underrun detect.
// Rev 1.0
// ---------------------------------------------------------------------------
module asg_loader_fill
  import asg_loader_pkg::*;
#(
  parameter int RSZ = 15
) (
  input  logic           dac_clk_i,
  input  logic           dac_rst_i,
  input  logic [RSZ-1:0] i_wpnt,
  input  logic [RSZ-1:0] i_rpnt,
  output logic [RSZ-1:0] o_fill,
  output logic [RSZ-1:0] o_fill_prev,
  output logic           o_undr
);

  logic [RSZ-1:0] w_fill;
  logic [RSZ-1:0] r_fill_prev;

  assign w_fill = i_wpnt - i_rpnt;

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      r_fill_prev <= '0;
    end else begin
      r_fill_prev <= w_fill;
    end
  end

  // Writes raise fill by at most one per cycle; a bigger jump means the
  // reader wrapped past the writer. Compared one bit wider to avoid wrap.
  assign o_undr = (w_fill == '0) ||
                  ({1'b0, w_fill} > ({1'b0, r_fill_prev} + {{RSZ{1'b0}}, 1'b1}));

  assign o_fill      = w_fill;
  assign o_fill_prev = r_fill_prev;

endmodule
`default_nettype wire

// File: rtl/red_pitaya_asg_stream_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// red_pitaya_asg_stream_loader : streams samples into an ASG circular buffer,
// primes it before playback and flags underrun. Optional counters via
// ASG_LOADER_STAT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module red_pitaya_asg_stream_loader
  import asg_loader_pkg::*;
#(
  parameter int RSZ   = 15,
  parameter int GUARD = c_guard_default
) (
  input  logic                  dac_clk_i,
  input  logic                  dac_rst_i,
  input  logic [c_sample_w-1:0] s_dat_i,
  input  logic                  s_vld_i,
  output logic                  s_rdy_o,
  input  logic [RSZ-1:0]        buf_rpnt_i,
  input  logic                  ctl_start_i,
  input  logic                  ctl_stop_i,
  input  logic [RSZ-1:0]        ctl_prime_i,
  output logic                  buf_we_o,
  output logic [RSZ-1:0]        buf_addr_o,
  output logic [c_sample_w-1:0] buf_wdata_o,
  output logic                  run_o,
  output logic [RSZ-1:0]        stat_fill_o,
  output logic                  stat_undr_o
`ifdef ASG_LOADER_STAT_EN
  ,
  output logic [31:0]           stat_acc_o,
  output logic [15:0]           stat_ucnt_o
`endif
);

  localparam logic [RSZ-1:0] c_fill_max = RSZ'((1 << RSZ) - GUARD);

  loader_state_t         r_state;
  loader_state_t         w_state_nxt;
  logic [RSZ-1:0]        r_wpnt;
  logic [RSZ-1:0]        w_wpnt_nxt;
  logic [RSZ-1:0]        w_fill;
  logic [RSZ-1:0]        w_fill_nxt;
  logic [RSZ-1:0]        w_fill_prev;
  logic                  w_undr;
  logic                  w_undr_evt;
  logic                  w_accept;
  logic                  w_start;
  logic                  w_rdy_nxt;
  logic                  r_rdy;
  logic                  r_we;
  logic [RSZ-1:0]        r_addr;
  logic [c_sample_w-1:0] r_wdata;
  logic                  r_undr;

  asg_loader_fill #(
    .RSZ (RSZ)
  ) u_fill (
    .dac_clk_i   (dac_clk_i),
    .dac_rst_i   (dac_rst_i),
    .i_wpnt      (r_wpnt),
    .i_rpnt      (buf_rpnt_i),
    .o_fill      (w_fill),
    .o_fill_prev (w_fill_prev),
    .o_undr      (w_undr)
  );

  assign w_accept   = s_vld_i & r_rdy;
  // A simultaneous stop cancels the start.
  assign w_start    = ctl_start_i & ~ctl_stop_i;
  assign w_undr_evt = (r_state == ST_STREAM) & w_undr;

  always_comb begin
    w_state_nxt = r_state;
    w_wpnt_nxt  = r_wpnt;
    if (w_accept) begin
      w_wpnt_nxt = r_wpnt + RSZ'(1);
    end
    case (r_state)
      ST_IDLE:   w_state_nxt = ST_IDLE;
      ST_PRIME:  if (w_fill >= ctl_prime_i) w_state_nxt = ST_STREAM;
      ST_STREAM: w_state_nxt = ST_STREAM;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (w_start) begin
      w_state_nxt = ST_PRIME;
      w_wpnt_nxt  = buf_rpnt_i;
    end
    if (ctl_stop_i) begin
      w_state_nxt = ST_IDLE;
    end
    // Ready looks one cycle ahead so the guard band is never crossed.
    w_fill_nxt = w_wpnt_nxt - buf_rpnt_i;
    w_rdy_nxt  = (w_state_nxt != ST_IDLE) && (w_fill_nxt < c_fill_max);
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      r_state <= ST_IDLE;
      r_wpnt  <= '0;
      r_rdy   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_undr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wpnt  <= w_wpnt_nxt;
      r_rdy   <= w_rdy_nxt;
      r_we    <= w_accept;
      if (w_accept) begin
        r_addr  <= r_wpnt;
        r_wdata <= s_dat_i;
      end
      if (w_start) begin
        r_undr <= 1'b0;
      end else if (w_undr_evt) begin
        r_undr <= 1'b1;
      end
    end
  end

`ifdef ASG_LOADER_STAT_EN
  logic [31:0] r_acc;
  logic [15:0] r_ucnt;

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i || w_start) begin
      r_acc  <= '0;
      r_ucnt <= '0;
    end else begin
      if (w_accept) begin
        r_acc <= r_acc + 32'd1;
      end
      if (w_undr_evt && (r_ucnt != 16'hFFFF)) begin
        r_ucnt <= r_ucnt + 16'd1;
      end
    end
  end

  assign stat_acc_o  = r_acc;
  assign stat_ucnt_o = r_ucnt;
`endif

  assign s_rdy_o     = r_rdy;
  assign buf_we_o    = r_we;
  assign buf_addr_o  = r_addr;
  assign buf_wdata_o = r_wdata;
  assign run_o       = (r_state == ST_STREAM);
  assign stat_fill_o = w_fill_prev;
  assign stat_undr_o = r_undr;

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_asg_stream_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_red_pitaya_asg_stream_loader : randomized bench with a session-level
// reference model of the stream loader.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_red_pitaya_asg_stream_loader;

  localparam int RSZ   = 6;
  localparam int GUARD = 4;
  localparam int DEPTH = 1 << RSZ;
  localparam int M_IDLE   = 0;
  localparam int M_PRIME  = 1;
  localparam int M_STREAM = 2;

  logic           dac_clk_i;
  logic           dac_rst_i;
  logic [13:0]    s_dat_i;
  logic           s_vld_i;
  logic           s_rdy_o;
  logic [RSZ-1:0] buf_rpnt_i;
  logic           ctl_start_i;
  logic           ctl_stop_i;
  logic [RSZ-1:0] ctl_prime_i;
  logic           buf_we_o;
  logic [RSZ-1:0] buf_addr_o;
  logic [13:0]    buf_wdata_o;
  logic           run_o;
  logic [RSZ-1:0] stat_fill_o;
  logic           stat_undr_o;
`ifdef ASG_LOADER_STAT_EN
  logic [31:0]    stat_acc_o;
  logic [15:0]    stat_ucnt_o;
`endif

  red_pitaya_asg_stream_loader #(
    .RSZ   (RSZ),
    .GUARD (GUARD)
  ) dut (
    .dac_clk_i   (dac_clk_i),
    .dac_rst_i   (dac_rst_i),
    .s_dat_i     (s_dat_i),
    .s_vld_i     (s_vld_i),
    .s_rdy_o     (s_rdy_o),
    .buf_rpnt_i  (buf_rpnt_i),
    .ctl_start_i (ctl_start_i),
    .ctl_stop_i  (ctl_stop_i),
    .ctl_prime_i (ctl_prime_i),
    .buf_we_o    (buf_we_o),
    .buf_addr_o  (buf_addr_o),
    .buf_wdata_o (buf_wdata_o),
    .run_o       (run_o),
    .stat_fill_o (stat_fill_o),
    .stat_undr_o (stat_undr_o)
`ifdef ASG_LOADER_STAT_EN
    ,
    .stat_acc_o  (stat_acc_o),
    .stat_ucnt_o (stat_ucnt_o)
`endif
  );

  initial dac_clk_i = 1'b0;
  always #5 dac_clk_i = ~dac_clk_i;

  int n_cmp = 0;
  int n_err = 0;
  int n_hs  = 0;
  int rp    = 0;
  int prime = 0;
  logic [13:0] cur_dat;

  // Reference model: session mode, write pointer and expected outputs.
  int   mode = M_IDLE;
  int   wp   = 0;
  bit   e_rdy, e_we, e_run, e_undr;
  int   e_addr, e_data, e_fill, e_acc, e_ucnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step(input bit vld, input bit st, input bit sp, input bit rs);
    int fill_now;
    bit acc;
    bit evt;
    s_vld_i     = vld;
    s_dat_i     = cur_dat;
    buf_rpnt_i  = RSZ'(rp);
    ctl_prime_i = RSZ'(prime);
    ctl_start_i = st;
    ctl_stop_i  = sp;
    dac_rst_i   = rs;
    if (vld && s_rdy_o) n_hs++;
    acc = vld && e_rdy;
    if (rs) begin
      mode = M_IDLE; wp = 0;
      e_rdy = 0; e_we = 0; e_run = 0; e_undr = 0;
      e_fill = 0; e_acc = 0; e_ucnt = 0;
    end else begin
      fill_now = (wp - rp + DEPTH) % DEPTH;
      evt = (mode == M_STREAM) && (fill_now == 0 || fill_now > e_fill + 1);
      if (evt) begin
        e_undr = 1;
        if (e_ucnt < 65535) e_ucnt++;
      end
      e_we = acc;
      if (acc) begin
        e_addr = wp;
        e_data = int'(cur_dat);
        e_acc++;
        wp = (wp + 1) % DEPTH;
      end
      if (sp) mode = M_IDLE;
      else if (st) begin
        mode = M_PRIME; wp = rp;
        e_undr = 0; e_ucnt = 0; e_acc = 0;
      end else if (mode == M_PRIME && fill_now >= prime) mode = M_STREAM;
      e_fill = fill_now;
      e_rdy  = (mode != M_IDLE) && (((wp - rp + DEPTH) % DEPTH) < DEPTH - GUARD);
      e_run  = (mode == M_STREAM);
    end
    @(posedge dac_clk_i);
    #1;
    chk("rdy",  32'(s_rdy_o),     32'(e_rdy));
    chk("we",   32'(buf_we_o),    32'(e_we));
    chk("run",  32'(run_o),       32'(e_run));
    chk("fill", 32'(stat_fill_o), 32'(e_fill));
    chk("undr", 32'(stat_undr_o), 32'(e_undr));
    if (e_we) begin
      chk("addr",  32'(buf_addr_o),  32'(e_addr));
      chk("wdata", 32'(buf_wdata_o), 32'(e_data));
    end
`ifdef ASG_LOADER_STAT_EN
    chk("acc",  stat_acc_o,        32'(e_acc));
    chk("ucnt", 32'(stat_ucnt_o),  32'(e_ucnt));
`endif
    if (acc && !rs) cur_dat = 14'($urandom);
  endtask

  initial begin
    int bound;
    int writes;
    cur_dat = 14'($urandom);
    s_vld_i = 0; s_dat_i = cur_dat; buf_rpnt_i = '0; ctl_start_i = 0;
    ctl_stop_i = 0; ctl_prime_i = '0; dac_rst_i = 1;
    e_addr = 0; e_data = 0;

    repeat (3) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("rst_addr",  32'(buf_addr_o),  32'd0);
    chk("rst_wdata", 32'(buf_wdata_o), 32'd0);

    // Test 1: frozen reader, continuous source.
    rp = 0; prime = 8;
    step(0, 1, 0, 0);
    n_hs = 0;
    repeat (70) step(1, 0, 0, 0);
    chk("t1_accepts", n_hs, 32'd60);
    chk("t1_rdy_low", 32'(s_rdy_o), 32'd0);

    // Test 2: reader advances every cycle, source half rate.
    repeat (200) begin
      rp = (rp + 1) % DEPTH;
      step(1'($urandom % 2), 0, 0, 0);
    end
    chk("t2_undr", 32'(stat_undr_o), 32'd1);
    chk("t2_run",  32'(run_o),       32'd1);

    // Test 3: reader pointer jumps past the writer.
    rp = 0; prime = 4;
    step(0, 1, 0, 0);
    n_hs = 0; bound = 0;
    while (n_hs < 20 && bound < 60) begin
      step(1, 0, 0, 0);
      bound++;
    end
    chk("t3_accepts", n_hs, 32'd20);
    rp = 10;
    repeat (3) step(0, 0, 0, 0);
    chk("t3_no_undr", 32'(stat_undr_o), 32'd0);
    rp = 30;
    repeat (3) step(0, 0, 0, 0);
    chk("t3_undr", 32'(stat_undr_o), 32'd1);
`ifdef ASG_LOADER_STAT_EN
    chk("t3_ucnt", 32'(stat_ucnt_o), 32'd1);
`endif

    // Test 4: stop during PRIME with an accept in the same cycle.
    rp = 0; prime = 40;
    step(0, 1, 0, 0);
    repeat (5) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    chk("t4_last_we", 32'(buf_we_o), 32'd1);
    chk("t4_rdy",     32'(s_rdy_o),  32'd0);
    chk("t4_run",     32'(run_o),    32'd0);
    step(0, 0, 0, 0);
    chk("t4_we_done", 32'(buf_we_o), 32'd0);

    // Test 5: start and stop together while idle.
    step(1, 1, 1, 0);
    writes = 0;
    repeat (5) begin
      step(1, 0, 0, 0);
      if (buf_we_o) writes++;
    end
    chk("t5_writes", writes, 32'd0);
    chk("t5_rdy",    32'(s_rdy_o), 32'd0);

    // Test 6: reset mid-stream with wpnt=33, then restart.
    rp = 0; prime = 4;
    step(0, 1, 0, 0);
    n_hs = 0; bound = 0;
    while (n_hs < 33 && bound < 80) begin
      step(1, 0, 0, 0);
      bound++;
    end
    chk("t6_accepts", n_hs, 32'd33);
    step(1, 0, 0, 1);
    chk("t6_rst_we",    32'(buf_we_o),    32'd0);
    chk("t6_rst_addr",  32'(buf_addr_o),  32'd0);
    chk("t6_rst_wdata", 32'(buf_wdata_o), 32'd0);
    chk("t6_rst_run",   32'(run_o),       32'd0);
    chk("t6_rst_fill",  32'(stat_fill_o), 32'd0);
    step(0, 0, 0, 0);
    rp = 17;
    step(0, 1, 0, 0);
    bound = 0;
    do begin
      step(1, 0, 0, 0);
      bound++;
    end while (!buf_we_o && bound < 10);
    chk("t6_first_addr", 32'(buf_addr_o), 32'd17);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int r;
      bit st;
      r = int'($urandom % 10);
      if (r < 6) rp = (rp + 1) % DEPTH;
      else if (r == 9) rp = int'($urandom % DEPTH);
      st = ($urandom % 40) == 0;
      if (st) prime = int'($urandom % 24);
      step(($urandom % 3) != 0, st, ($urandom % 70) == 0, ($urandom % 250) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
